// File: rtl/ay_pkg.sv
// Shared definitions for the AY-3-8910 bus interface: command bit positions,
// register indices and the per-register implemented-width mask.
package ay_pkg;

  localparam int CMD_INACT = 0;
  localparam int CMD_LADDR = 1;
  localparam int CMD_WRPSG = 2;
  localparam int CMD_RDPSG = 3;

  localparam logic [3:0] R_ENV_SHAPE = 4'd13;
  localparam logic [3:0] R_MIXER     = 4'd7;

  // Bits that physically exist in each register; unimplemented bits read 0.
  function automatic logic [7:0] ay_reg_mask(input logic [3:0] idx);
    case (idx)
      4'd1, 4'd3, 4'd5, R_ENV_SHAPE: ay_reg_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10:       ay_reg_mask = 8'h1F;
      default:                       ay_reg_mask = 8'hFF;
    endcase
  endfunction

  // True when more than one command line is high at once.
  function automatic logic ay_multi_hot(input logic [3:0] v);
    ay_multi_hot = |(v & (v - 4'd1));
  endfunction

endpackage

// File: rtl/ay_psg_bus_if_sync_edge.sv
// One-bit N-stage synchronizer followed by a history flop, giving the current
// and previous synchronized levels for edge detection.
module ay_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_sync,
  output logic o_prev
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_prev = r_prev;

endmodule

// File: rtl/ay_psg_bus_if.sv
// AY-3-8910 bus interface: synchronizes the pseudo-commands and data bus,
// latches the register address, commits masked writes and returns read data.
module ay_psg_bus_if
  import ay_pkg::*;
#(
  parameter logic [3:0] ADDR_HI     = 4'b0000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ay_inact,
  input  logic         ay_laddr,
  input  logic         ay_wrpsg,
  input  logic         ay_rdpsg,
  input  logic [7:0]   da_in,
  output logic [7:0]   da_out,
  output logic         da_oe,
  output logic [127:0] regs_flat,
  output logic         env_restart,
  output logic         bus_err
);

  logic [3:0] w_cmd_raw, w_cmd_sync, w_cmd_prev;
  logic [SYNC_STAGES-1:0][7:0] r_da_pipe;
  logic [7:0] w_da_sync;

  assign w_cmd_raw = {ay_rdpsg, ay_wrpsg, ay_laddr, ay_inact};

  for (genvar g = 0; g < 4; g++) begin : g_cmd
    ay_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .i_d    (w_cmd_raw[g]),
      .o_sync (w_cmd_sync[g]),
      .o_prev (w_cmd_prev[g])
    );
  end

  // Data shares the command depth so a captured byte belongs to its command.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_da_pipe <= '0;
    end else begin
      r_da_pipe[0] <= da_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_da_pipe[i] <= r_da_pipe[i-1];
    end
  end
  assign w_da_sync = r_da_pipe[SYNC_STAGES-1];

  logic w_multi, w_multi_prev;
  logic w_laddr_act, w_wr_act, w_rd_act;
  logic w_laddr_fall, w_wr_fall, w_commit;

  assign w_multi      = ay_multi_hot(w_cmd_sync);
  assign w_multi_prev = ay_multi_hot(w_cmd_prev);
  assign w_laddr_act  = ~w_multi & w_cmd_sync[CMD_LADDR];
  assign w_wr_act     = ~w_multi & w_cmd_sync[CMD_WRPSG];
  assign w_rd_act     = ~w_multi & w_cmd_sync[CMD_RDPSG];
  // A release only counts when the command was previously the sole active one.
  assign w_laddr_fall = ~w_multi_prev & w_cmd_prev[CMD_LADDR] & ~w_cmd_sync[CMD_LADDR];
  assign w_wr_fall    = ~w_multi_prev & w_cmd_prev[CMD_WRPSG] & ~w_cmd_sync[CMD_WRPSG];

  logic [7:0]       r_addr_cap, r_wdata_cap;
  logic [3:0]       r_addr;
  logic             r_sel;
  logic [15:0][7:0] r_regs;
  logic [7:0]       r_da_out;
  logic             r_da_oe, r_env, r_bus_err;
  logic [7:0]       w_wdata_masked, w_rd_data;
  logic [3:0]       w_rd_addr;
  logic             w_rd_sel;

  assign w_commit       = w_wr_fall & r_sel;
  assign w_wdata_masked = r_wdata_cap & ay_reg_mask(r_addr);
  // Forward an address or write landing this cycle so back-to-back reads see it.
  assign w_rd_addr = w_laddr_fall ? r_addr_cap[3:0] : r_addr;
  assign w_rd_sel  = w_laddr_fall ? (r_addr_cap[7:4] == ADDR_HI) : r_sel;
  assign w_rd_data = (w_commit && (r_addr == w_rd_addr)) ? w_wdata_masked : r_regs[w_rd_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr_cap  <= '0;
      r_wdata_cap <= '0;
      r_addr      <= '0;
      r_sel       <= 1'b0;
      r_regs      <= '0;
      r_da_out    <= '0;
      r_da_oe     <= 1'b0;
      r_env       <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      if (w_laddr_act) r_addr_cap  <= w_da_sync;
      if (w_wr_act)    r_wdata_cap <= w_da_sync;
      if (w_laddr_fall) begin
        r_addr <= r_addr_cap[3:0];
        r_sel  <= (r_addr_cap[7:4] == ADDR_HI);
      end
      if (w_commit) r_regs[r_addr] <= w_wdata_masked;
      r_env     <= w_commit && (r_addr == R_ENV_SHAPE);
      r_da_oe   <= w_rd_act & w_rd_sel;
      r_da_out  <= (w_rd_act & w_rd_sel) ? w_rd_data : 8'h00;
      r_bus_err <= w_multi & ~w_multi_prev;
    end
  end

  assign regs_flat   = r_regs;
  assign da_out      = r_da_out;
  assign da_oe       = r_da_oe;
  assign env_restart = r_env;
  assign bus_err     = r_bus_err;

endmodule

// File: tb/tb_ay_psg_bus_if.sv
// Self-checking bench for ay_psg_bus_if against a register-file model kept
// at the level of "address, selected flag, sixteen masked bytes".
module tb_ay_psg_bus_if;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         ay_inact, ay_laddr, ay_wrpsg, ay_rdpsg;
  logic [7:0]   da_in, da_out;
  logic         da_oe;
  logic [127:0] regs_flat;
  logic         env_restart, bus_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0] m_regs [16];
  logic [3:0] m_addr;
  logic       m_sel;

  int   env_cnt = 0, env_wide = 0, err_cnt = 0, err_wide = 0, oe_cnt = 0;
  logic env_prev = 1'b0, err_prev = 1'b0;

  always #5 clk = ~clk;

  ay_psg_bus_if #(.ADDR_HI(4'b0000), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .reset       (reset),
    .ay_inact    (ay_inact),
    .ay_laddr    (ay_laddr),
    .ay_wrpsg    (ay_wrpsg),
    .ay_rdpsg    (ay_rdpsg),
    .da_in       (da_in),
    .da_out      (da_out),
    .da_oe       (da_oe),
    .regs_flat   (regs_flat),
    .env_restart (env_restart),
    .bus_err     (bus_err)
  );

  // Pulse counters sampled mid-cycle; a wide count flags pulses longer than one cycle.
  always @(negedge clk) begin
    if (env_restart) env_cnt++;
    if (env_restart && env_prev) env_wide++;
    if (bus_err) err_cnt++;
    if (bus_err && err_prev) err_wide++;
    if (da_oe) oe_cnt++;
    env_prev = env_restart;
    err_prev = bus_err;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    step(LAT + 1);
  endtask

  function automatic logic [7:0] spec_mask(input int idx);
    case (idx)
      1, 3, 5, 13: return 8'h0F;
      6, 8, 9, 10: return 8'h1F;
      default:     return 8'hFF;
    endcase
  endfunction

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_addr = 4'h0;
    m_sel  = 1'b0;
  endtask

  task automatic model_laddr(input logic [7:0] d);
    m_addr = d[3:0];
    m_sel  = (d[7:4] == 4'h0);
  endtask

  task automatic model_write(input logic [7:0] d);
    if (m_sel) m_regs[m_addr] = d & spec_mask(int'(m_addr));
  endtask

  task automatic drive_idle();
    ay_inact = 1'b1;
    ay_laddr = 1'b0;
    ay_wrpsg = 1'b0;
    ay_rdpsg = 1'b0;
  endtask

  task automatic do_laddr(input logic [7:0] d, input int hold);
    ay_inact = 1'b0;
    ay_laddr = 1'b1;
    da_in    = d;
    step(hold);
    drive_idle();
    da_in = 8'($urandom);
    model_laddr(d);
  endtask

  task automatic do_write(input logic [7:0] d, input int hold);
    ay_inact = 1'b0;
    ay_wrpsg = 1'b1;
    da_in    = d;
    step(hold);
    drive_idle();
    da_in = 8'($urandom);
    model_write(d);
  endtask

  task automatic do_laddr_write(input logic [7:0] a, input logic [7:0] d);
    ay_inact = 1'b0;
    ay_laddr = 1'b1;
    da_in    = a;
    step($urandom_range(1, 3));
    ay_laddr = 1'b0;
    ay_wrpsg = 1'b1;
    da_in    = d;
    step($urandom_range(1, 3));
    drive_idle();
    da_in = 8'($urandom);
    model_laddr(a);
    model_write(d);
  endtask

  task automatic check_regs(input string name);
    chk_cnt++;
    if (regs_flat !== model_flat())
      $display("FAIL %s: regs_flat got %h expected %h", name, regs_flat, model_flat());
    else pass_cnt++;
  endtask

  task automatic do_read(input string name);
    ay_inact = 1'b0;
    ay_rdpsg = 1'b1;
    step(LAT);
    chk_cnt++;
    if (m_sel) begin
      if ({da_oe, da_out} !== {1'b1, m_regs[m_addr]})
        $display("FAIL %s: oe/data got %b/%h expected 1/%h", name, da_oe, da_out, m_regs[m_addr]);
      else pass_cnt++;
    end else begin
      if (da_oe !== 1'b0) $display("FAIL %s: da_oe got %b expected 0", name, da_oe);
      else pass_cnt++;
    end
    drive_idle();
    settle();
    chk_cnt++;
    if (da_oe !== 1'b0) $display("FAIL %s_release: da_oe got %b expected 0", name, da_oe);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    da_in = 8'h00;
    step(4);
    model_reset();
    check_regs("reset_regs");
    chk_cnt++;
    if ({da_oe, da_out} !== 9'h000) $display("FAIL reset_rd: got %b/%h expected 0/00", da_oe, da_out);
    else pass_cnt++;
    chk_cnt++;
    if ({env_restart, bus_err} !== 2'b00)
      $display("FAIL reset_pulses: got %b%b expected 00", env_restart, bus_err);
    else pass_cnt++;
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_basic();
    do_laddr(8'h07, 2);
    do_write(8'hFF, 2);
    settle();
    check_regs("basic_regs");
    chk_cnt++;
    if (regs_flat[63:56] !== 8'hFF) $display("FAIL basic_r7: got %h expected ff", regs_flat[63:56]);
    else pass_cnt++;
    ay_inact = 1'b0;
    ay_rdpsg = 1'b1;
    step(LAT - 1);
    chk_cnt++;
    if (da_oe !== 1'b0) $display("FAIL rd_early: da_oe got %b expected 0", da_oe);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if ({da_oe, da_out} !== {1'b1, 8'hFF})
      $display("FAIL rd_latency: got %b/%h expected 1/ff", da_oe, da_out);
    else pass_cnt++;
    drive_idle();
    step(LAT - 1);
    chk_cnt++;
    if (da_oe !== 1'b1) $display("FAIL rd_hold: da_oe got %b expected 1", da_oe);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if (da_oe !== 1'b0) $display("FAIL rd_drop: da_oe got %b expected 0", da_oe);
    else pass_cnt++;
  endtask

  task automatic test_write_latency();
    do_laddr(8'h04, 1);
    ay_inact = 1'b0;
    ay_wrpsg = 1'b1;
    da_in    = 8'h96;
    step(2);
    drive_idle();
    model_write(8'h96);
    step(LAT - 1);
    chk_cnt++;
    if (regs_flat[39:32] === 8'h96) $display("FAIL wr_early: R4 got %h expected old value", regs_flat[39:32]);
    else pass_cnt++;
    step(1);
    check_regs("wr_latency");
  endtask

  task automatic test_masks();
    do_laddr(8'h01, 1);
    do_write(8'hAB, 2);
    settle();
    chk_cnt++;
    if (regs_flat[15:8] !== 8'h0B) $display("FAIL mask_r1: got %h expected 0b", regs_flat[15:8]);
    else pass_cnt++;
    do_laddr(8'h06, 3);
    do_write(8'hFF, 1);
    settle();
    chk_cnt++;
    if (regs_flat[55:48] !== 8'h1F) $display("FAIL mask_r6: got %h expected 1f", regs_flat[55:48]);
    else pass_cnt++;
    do_read("read_r6");
  endtask

  task automatic test_env();
    int e0, w0;
    e0 = env_cnt;
    w0 = env_wide;
    do_laddr(8'h0D, 2);
    do_write(8'h0E, 2);
    settle();
    check_regs("env_regs");
    chk_cnt++;
    if (env_cnt - e0 !== 1) $display("FAIL env_first: pulses got %0d expected 1", env_cnt - e0);
    else pass_cnt++;
    do_write(8'h0E, 1);
    settle();
    chk_cnt++;
    if (env_cnt - e0 !== 2) $display("FAIL env_repeat: pulses got %0d expected 2", env_cnt - e0);
    else pass_cnt++;
    chk_cnt++;
    if (env_wide !== w0) $display("FAIL env_width: wide pulses got %0d expected %0d", env_wide, w0);
    else pass_cnt++;
  endtask

  task automatic test_unselected();
    int oe0;
    do_laddr(8'h15, 2);
    do_write(8'h55, 2);
    settle();
    check_regs("unsel_write");
    oe0 = oe_cnt;
    do_read("unsel_read");
    chk_cnt++;
    if (oe_cnt !== oe0) $display("FAIL unsel_oe: oe cycles got %0d expected %0d", oe_cnt, oe0);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    int e0, w0, oe0;
    do_laddr(8'h03, 1);
    settle();
    e0  = err_cnt;
    w0  = err_wide;
    oe0 = oe_cnt;
    ay_inact = 1'b0;
    ay_wrpsg = 1'b1;
    ay_rdpsg = 1'b1;
    da_in    = 8'h5A;
    step(4);
    drive_idle();
    settle();
    chk_cnt++;
    if (err_cnt - e0 !== 1) $display("FAIL illegal_err: pulses got %0d expected 1", err_cnt - e0);
    else pass_cnt++;
    chk_cnt++;
    if (err_wide !== w0) $display("FAIL illegal_width: wide got %0d expected %0d", err_wide, w0);
    else pass_cnt++;
    check_regs("illegal_nowrite");
    chk_cnt++;
    if (oe_cnt !== oe0) $display("FAIL illegal_oe: oe cycles got %0d expected %0d", oe_cnt, oe0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_laddr(8'h02, 1);
    settle();
    ay_inact = 1'b0;
    ay_wrpsg = 1'b1;
    da_in    = 8'hC3;
    step(2);
    reset = 1'b1;
    step(2);
    model_reset();
    check_regs("midreset_clear");
    reset = 1'b0;
    da_in = 8'h3C;
    step(3);
    drive_idle();
    settle();
    check_regs("midreset_after");
    chk_cnt++;
    if ({regs_flat[23:16], regs_flat[7:0]} !== 16'h0000)
      $display("FAIL midreset_r2r0: got %h/%h expected 00/00", regs_flat[23:16], regs_flat[7:0]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    do_laddr_write(8'h09, 8'hE7);
    settle();
    check_regs("b2b_laddr_wr");
    d = 8'($urandom);
    ay_inact = 1'b0;
    ay_wrpsg = 1'b1;
    da_in    = d;
    step(2);
    ay_wrpsg = 1'b0;
    ay_rdpsg = 1'b1;
    da_in    = 8'($urandom);
    model_write(d);
    step(LAT);
    chk_cnt++;
    if ({da_oe, da_out} !== {1'b1, m_regs[m_addr]})
      $display("FAIL b2b_wr_rd: got %b/%h expected 1/%h", da_oe, da_out, m_regs[m_addr]);
    else pass_cnt++;
    drive_idle();
    settle();
    check_regs("b2b_regs");
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int n = 0; n < 40; n++) begin
      a = {($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, 4'($urandom)};
      case ($urandom_range(0, 3))
        0: do_laddr(a, $urandom_range(1, 3));
        1: do_write(8'($urandom), $urandom_range(1, 3));
        2: do_read("rand_read");
        default: do_laddr_write(a, 8'($urandom));
      endcase
      settle();
      check_regs("rand_regs");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_write_latency();
    test_masks();
    test_env();
    test_unselected();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
